// File: rtl/fifo_uart_tx.sv
// Serial transmitter that drains a show-ahead FIFO: start bit, BITS data bits LSB-first,
// optional even parity, stop bit. All outputs except the pop strobe are registered.
module fifo_uart_tx #(
   parameter int BITS         = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [BITS-1:0] Din,
   input  logic            pndng,
   output logic            pop,
   input  logic            enable,
   output logic            tx,
   output logic            busy,
   output logic            done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (BITS > 1) ? $clog2(BITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [BITS-1:0] shift_q, shift_d;
   logic            par_q, par_d;
   logic            tx_q, tx_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            bit_end;

   // rst is folded in so the strobe is low while reset is held, even with a word pending
   assign pop     = rst && (state_q == IDLE) && enable && pndng;
   assign bit_end = (cnt_q == CNT_LAST);
   assign tx      = tx_q;
   assign busy    = busy_q;
   assign done    = done_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = 1'b1;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (pop) begin
               shift_d = Din;
               par_d   = ^Din;
               state_d = START;
            end
         end
         START:  if (bit_end) begin
            state_d = DATA;
            idx_d   = '0;
         end
         DATA:   if (bit_end) begin
            if (idx_q == IDX_LAST) state_d = (PARITY_EN != 0) ? PARITY : STOP;
            else                   idx_d   = idx_q + 1'b1;
         end
         PARITY: if (bit_end) state_d = STOP;
         STOP:   if (bit_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are registered, so they are derived from the state being entered
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[idx_d];
         PARITY:  tx_d = par_d;
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: three transmitter instances (C=4 no parity, C=2 parity, C=1 no parity)
// with the FIFO head word and pndng driven directly by the stimulus sequence.
module tb_fifo_uart_tx;

   logic             clk;
   logic             rst;
   logic [2:0][7:0]  din_v;
   logic [2:0]       pndng_v, en_v, pop_v, tx_v, busy_v, done_v;

   int n_cmp = 0;
   int n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   fifo_uart_tx #(.BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut_a (
      .clk(clk), .rst(rst), .Din(din_v[0]), .pndng(pndng_v[0]), .pop(pop_v[0]),
      .enable(en_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
   fifo_uart_tx #(.BITS(8), .CLKS_PER_BIT(2), .PARITY_EN(1)) dut_b (
      .clk(clk), .rst(rst), .Din(din_v[1]), .pndng(pndng_v[1]), .pop(pop_v[1]),
      .enable(en_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
   fifo_uart_tx #(.BITS(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_c (
      .clk(clk), .rst(rst), .Din(din_v[2]), .pndng(pndng_v[2]), .pop(pop_v[2]),
      .enable(en_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

   function automatic int cpb(int d);
      return (d == 0) ? 4 : (d == 1) ? 2 : 1;
   endfunction

   function automatic int par_en(int d);
      return (d == 1) ? 1 : 0;
   endfunction

   // Line level expected k cycles after the pop cycle (k = 1 is the first start-bit cycle)
   function automatic logic exp_tx(int d, logic [7:0] w, int k);
      int seg;
      seg = (k - 1) / cpb(d);
      if (seg == 0) return 1'b0;
      if (seg <= 8) return w[seg-1];
      if (par_en(d) == 1 && seg == 9) return ^w;
      return 1'b1;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at the negedge where pop must be high; checks the whole frame and leaves
   // the bench at the negedge of the done cycle. Loads the next FIFO head after the pop.
   task automatic frame(int d, logic [7:0] w, logic [7:0] nxt, logic nxt_v, int drop_en_k);
      int len;
      len = (2 + 8 + par_en(d)) * cpb(d);
      chk($sformatf("pop_hi d%0d w%0h", d, w), {31'd0, pop_v[d]}, 32'd1);
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         if (k == 1) begin
            din_v[d]   = nxt;
            pndng_v[d] = nxt_v;
         end
         if (k == drop_en_k) en_v[d] = 1'b0;
         chk($sformatf("tx d%0d w%0h k%0d", d, w, k), {31'd0, tx_v[d]}, {31'd0, exp_tx(d, w, k)});
         chk($sformatf("busy d%0d k%0d", d, k), {31'd0, busy_v[d]}, 32'd1);
         chk($sformatf("done d%0d k%0d", d, k), {31'd0, done_v[d]}, {31'd0, k == len});
         chk($sformatf("pop_lo d%0d k%0d", d, k), {31'd0, pop_v[d]}, 32'd0);
      end
   endtask

   task automatic idle_chk(int d, int n, string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk($sformatf("%s pop c%0d", tag, i), {31'd0, pop_v[d]}, 32'd0);
         chk($sformatf("%s tx c%0d", tag, i), {31'd0, tx_v[d]}, 32'd1);
         chk($sformatf("%s busy c%0d", tag, i), {31'd0, busy_v[d]}, 32'd0);
      end
   endtask

   initial begin
      logic [7:0] words [16];

      rst = 1'b0; din_v = '0; pndng_v = '0; en_v = '0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst tx d%0d", d), {31'd0, tx_v[d]}, 32'd1);
         chk($sformatf("rst busy d%0d", d), {31'd0, busy_v[d]}, 32'd0);
         chk($sformatf("rst done d%0d", d), {31'd0, done_v[d]}, 32'd0);
         chk($sformatf("rst pop d%0d", d), {31'd0, pop_v[d]}, 32'd0);
      end
      rst = 1'b1;
      @(negedge clk);

      // Single frame 0xA5, FIFO then empty
      en_v[0] = 1'b1; din_v[0] = 8'hA5; pndng_v[0] = 1'b1;
      #1;
      frame(0, 8'hA5, 8'h00, 1'b0, 0);
      idle_chk(0, 5, "after_a5");

      // Back-to-back drain of 16 words, 41-cycle pop spacing
      for (int i = 0; i < 16; i++) words[i] = 8'($urandom);
      din_v[0] = words[0]; pndng_v[0] = 1'b1;
      #1;
      for (int i = 0; i < 16; i++) begin
         frame(0, words[i], (i < 15) ? words[i+1] : 8'h00, i < 15, 0);
         if (i < 15) @(negedge clk);
      end
      chk("drain pndng", {31'd0, pndng_v[0]}, 32'd0);
      idle_chk(0, 20, "drain_end");

      // Parity: 0x07 -> parity 1, 0x03 -> parity 0, 22-cycle frames
      en_v[1] = 1'b1; din_v[1] = 8'h07; pndng_v[1] = 1'b1;
      #1;
      frame(1, 8'h07, 8'h03, 1'b1, 0);
      @(negedge clk);
      frame(1, 8'h03, 8'h00, 1'b0, 0);
      idle_chk(1, 3, "par_end");

      // Enable gating: pending word held off, then enable dropped mid-frame
      en_v[0] = 1'b0; din_v[0] = 8'h3C; pndng_v[0] = 1'b1;
      idle_chk(0, 100, "en_off");
      en_v[0] = 1'b1;
      #1;
      frame(0, 8'h3C, 8'h99, 1'b1, 20);
      idle_chk(0, 20, "en_drop");

      // Reset asserted between edges during data bit 3 of 0x52 (bit 3 is 0)
      din_v[0] = 8'h52; pndng_v[0] = 1'b1; en_v[0] = 1'b1;
      #1;
      chk("rst_mid pop", {31'd0, pop_v[0]}, 32'd1);
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         if (k == 1) din_v[0] = 8'h81;
      end
      chk("rst_mid tx_bit3", {31'd0, tx_v[0]}, 32'd0);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_mid tx", {31'd0, tx_v[0]}, 32'd1);
      chk("rst_mid busy", {31'd0, busy_v[0]}, 32'd0);
      chk("rst_mid pop_lo", {31'd0, pop_v[0]}, 32'd0);
      chk("rst_mid done", {31'd0, done_v[0]}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("rst_hold tx", {31'd0, tx_v[0]}, 32'd1);
      chk("rst_hold pop", {31'd0, pop_v[0]}, 32'd0);
      rst = 1'b1;
      #1;
      frame(0, 8'h81, 8'h00, 1'b0, 0);
      idle_chk(0, 3, "rst_end");

      // One clock per bit: two 0xFF frames with 11-cycle pop spacing
      en_v[2] = 1'b1; din_v[2] = 8'hFF; pndng_v[2] = 1'b1;
      #1;
      frame(2, 8'hFF, 8'hFF, 1'b1, 0);
      @(negedge clk);
      frame(2, 8'hFF, 8'h00, 1'b0, 0);
      idle_chk(2, 5, "c1_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
